multi_clock_divider: RTL and testbench

Parametrised successor to the single fixed-ratio divider: CHANNELS independent square-wave dividers driven from one system clock, each with a runtime-programmable half-period, per-channel enable, glitch-free reprogramming and a one-cycle toggle strobe. Sits between the board clock and slow consumers (display multiplexers, LED blinkers, debouncers). Consumers use either the divided clock or, preferably, the strobe as a clock enable.

---
 rtl/clkdiv_pkg.sv | 18 +
 rtl/clkdiv_channel.sv | 224 ++++++++++++++++++++++
 rtl/multi_clock_divider.sv | 52 +++++
 tb/tb_multi_clock_divider.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clkdiv_pkg;

   // Divisor loaded into every channel when reset is asserted
   localparam int unsigned DEFAULT_DIV  = 25000000;
   // Upper bound on the number of divider channels
   localparam int unsigned MAX_CHANNELS = 8;
   // Natural divisor width
   localparam int unsigned DIV_WIDTH    = 32;

   typedef logic [DIV_WIDTH-1:0] div_t;

   // Channel-select width; never narrower than one bit
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : clkdiv_pkg

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor(s), pending flag,
// registered square-wave output and toggle strobe.
// CLKDIV_DUTY_EN: separate high/low divisors, each with its own shadow.
module clkdiv_channel #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = 3
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             wr_i,
`ifdef CLKDIV_DUTY_EN
   input  logic             wr_high_i,
`endif
   input  logic [WIDTH-1:0] wr_div_i,
   output logic             clk_o,
   output logic             tick_o,
   output logic             pending_o
);

   import clkdiv_pkg::*;

   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic [WIDTH-1:0] limit;
   logic             terminal;

`ifdef CLKDIV_DUTY_EN

   logic [WIDTH-1:0] div_hi_q, div_hi_d, div_lo_q, div_lo_d;
   logic [WIDTH-1:0] shd_hi_q, shd_hi_d, shd_lo_q, shd_lo_d;
   logic             pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             wr_hi, wr_lo;

   assign wr_hi = wr_i & wr_high_i;
   assign wr_lo = wr_i & ~wr_high_i;

   // High phase is measured against H, low phase against L
   assign limit    = clk_q ? div_hi_q : div_lo_q;
   // >= rather than == so a stray count above the limit still wraps
   assign terminal = (count_q >= limit);

   // Next-state: phase counting, boundary updates and shadow writes
   always_comb begin
      count_d   = count_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      div_hi_d  = div_hi_q;
      div_lo_d  = div_lo_q;
      shd_hi_d  = shd_hi_q;
      shd_lo_d  = shd_lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;

      if (!en_i) begin
         // Idle: hold low, flush any waiting shadow straight away
         count_d = '0;
         clk_d   = 1'b0;
         if (pend_hi_q) begin
            div_hi_d  = shd_hi_q;
            pend_hi_d = 1'b0;
         end
         if (pend_lo_q) begin
            div_lo_d  = shd_lo_q;
            pend_lo_d = 1'b0;
         end
         if (wr_hi) begin
            shd_hi_d  = wr_div_i;
            pend_hi_d = 1'b1;
         end
         if (wr_lo) begin
            shd_lo_d  = wr_div_i;
            pend_lo_d = 1'b1;
         end
      end else if (terminal) begin
         // Phase boundary: toggle and apply whatever is waiting
         count_d = '0;
         clk_d   = ~clk_q;
         tick_d  = 1'b1;
         if (pend_hi_q) begin
            div_hi_d  = shd_hi_q;
            pend_hi_d = 1'b0;
         end
         if (pend_lo_q) begin
            div_lo_d  = shd_lo_q;
            pend_lo_d = 1'b0;
         end
         // A write landing on the boundary itself takes effect at once
         if (wr_hi) begin
            div_hi_d  = wr_div_i;
            shd_hi_d  = wr_div_i;
            pend_hi_d = 1'b0;
         end
         if (wr_lo) begin
            div_lo_d  = wr_div_i;
            shd_lo_d  = wr_div_i;
            pend_lo_d = 1'b0;
         end
      end else begin
         count_d = count_q + ONE;
         if (wr_hi) begin
            shd_hi_d  = wr_div_i;
            pend_hi_d = 1'b1;
         end
         if (wr_lo) begin
            shd_lo_d  = wr_div_i;
            pend_lo_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q   <= '0;
         clk_q     <= 1'b0;
         tick_q    <= 1'b0;
         div_hi_q  <= RST_DIV;
         div_lo_q  <= RST_DIV;
         shd_hi_q  <= RST_DIV;
         shd_lo_q  <= RST_DIV;
         pend_hi_q <= 1'b0;
         pend_lo_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         clk_q     <= clk_d;
         tick_q    <= tick_d;
         div_hi_q  <= div_hi_d;
         div_lo_q  <= div_lo_d;
         shd_hi_q  <= shd_hi_d;
         shd_lo_q  <= shd_lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   assign pending_o = pend_hi_q | pend_lo_q;

`else

   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] shd_q, shd_d;
   logic             pend_q, pend_d;

   assign limit    = div_q;
   // >= rather than == so a stray count above the limit still wraps
   assign terminal = (count_q >= limit);

   // Next-state: half-period counting, boundary updates and shadow writes
   always_comb begin
      count_d = count_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
      div_d   = div_q;
      shd_d   = shd_q;
      pend_d  = pend_q;

      if (!en_i) begin
         // Idle: hold low, flush any waiting shadow straight away
         count_d = '0;
         clk_d   = 1'b0;
         if (pend_q) begin
            div_d  = shd_q;
            pend_d = 1'b0;
         end
         if (wr_i) begin
            shd_d  = wr_div_i;
            pend_d = 1'b1;
         end
      end else if (terminal) begin
         // Half-period boundary: toggle and apply a waiting shadow
         count_d = '0;
         clk_d   = ~clk_q;
         tick_d  = 1'b1;
         if (pend_q) begin
            div_d  = shd_q;
            pend_d = 1'b0;
         end
         // A write landing on the boundary itself takes effect at once
         if (wr_i) begin
            div_d  = wr_div_i;
            shd_d  = wr_div_i;
            pend_d = 1'b0;
         end
      end else begin
         count_d = count_q + ONE;
         if (wr_i) begin
            shd_d  = wr_div_i;
            pend_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
         div_q   <= RST_DIV;
         shd_q   <= RST_DIV;
         pend_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
         div_q   <= div_d;
         shd_q   <= shd_d;
         pend_q  <= pend_d;
      end
   end

   assign pending_o = pend_q;

`endif

   assign clk_o  = clk_q;
   assign tick_o = tick_q;

endmodule : clkdiv_channel

// File: rtl/multi_clock_divider.sv
// CHANNELS independent programmable square-wave dividers sharing one clock.
// CLKDIV_DUTY_EN: adds wrHigh to select the high (1) or low (0) divisor.
module multi_clock_divider #(
   parameter  int unsigned CHANNELS    = 2,
   parameter  int unsigned WIDTH       = $bits(clkdiv_pkg::div_t),
   parameter  int unsigned DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV,
   localparam int unsigned CW          = clkdiv_pkg::sel_width(CHANNELS)
)(
   input  logic                clkIN,
   input  logic                rst,
   input  logic                wrEn,
   input  logic [CW-1:0]       wrCh,
   input  logic [WIDTH-1:0]    wrDiv,
`ifdef CLKDIV_DUTY_EN
   input  logic                wrHigh,
`endif
   input  logic [CHANNELS-1:0] chEn,
   output logic [CHANNELS-1:0] clkOUT,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pending
);

   import clkdiv_pkg::*;

   logic [CHANNELS-1:0] wr_stb;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         // Address decode; channel numbers beyond CHANNELS match nothing
         assign wr_stb[gi] = wrEn && (int'(wrCh) == gi);

         clkdiv_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
         ) u_ch (
            .clk_i     (clkIN),
            .rst_i     (rst),
            .en_i      (chEn[gi]),
            .wr_i      (wr_stb[gi]),
`ifdef CLKDIV_DUTY_EN
            .wr_high_i (wrHigh),
`endif
            .wr_div_i  (wrDiv),
            .clk_o     (clkOUT[gi]),
            .tick_o    (tick[gi]),
            .pending_o (pending[gi])
         );
      end
   endgenerate

endmodule : multi_clock_divider

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: CHANNELS=2, DEFAULT_DIV=3. Expected ticks
// (cycle, level) are queued per channel; a monitor checks each tick.
module tb_multi_clock_divider;

   localparam int CH = 2;
   localparam int W  = 32;

   typedef struct {
      int   cyc;
      logic lvl;
   } exp_t;

   logic          clkIN = 1'b0;
   logic          rst;
   logic          wrEn;
   logic [0:0]    wrCh;
   logic [W-1:0]  wrDiv;
`ifdef CLKDIV_DUTY_EN
   logic          wrHigh = 1'b0;
`endif
   logic [CH-1:0] chEn;
   logic [CH-1:0] clkOUT;
   logic [CH-1:0] tick;
   logic [CH-1:0] pending;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e_mon;

   multi_clock_divider #(
      .CHANNELS    (CH),
      .WIDTH       (W),
      .DEFAULT_DIV (3)
   ) dut (
      .clkIN   (clkIN),
      .rst     (rst),
      .wrEn    (wrEn),
      .wrCh    (wrCh),
      .wrDiv   (wrDiv),
`ifdef CLKDIV_DUTY_EN
      .wrHigh  (wrHigh),
`endif
      .chEn    (chEn),
      .clkOUT  (clkOUT),
      .tick    (tick),
      .pending (pending)
   );

   always #5 clkIN = ~clkIN;
   always @(posedge clkIN) cyc <= cyc + 1;

   task automatic push(input int ch, input int c, input logic lvl);
      exp_t e;
      e.cyc = c;
      e.lvl = lvl;
      if (ch == 0) q0.push_back(e);
      else         q1.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc %0d got %0h want %0h", name, cyc, act, req);
      end else begin
         $display("ok   %s cyc %0d value %0h", name, cyc, act);
      end
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clkIN);
   endtask

   // Monitor: every tick must match the head of that channel's queue
   always @(negedge clkIN) begin
      if (!done) begin
         for (int c = 0; c < CH; c++) begin
            int n;
            n = (c == 0) ? q0.size() : q1.size();
            if (tick[c]) begin
               checks++;
               if (n == 0) begin
                  errors++;
                  $display("FAIL tick_unexpected ch%0d cyc %0d got tick want none", c, cyc);
               end else begin
                  if (c == 0) e_mon = q0.pop_front();
                  else        e_mon = q1.pop_front();
                  if (e_mon.cyc != cyc || e_mon.lvl !== clkOUT[c]) begin
                     errors++;
                     $display("FAIL tick_ch%0d got cyc %0d lvl %0b want cyc %0d lvl %0b",
                              c, cyc, clkOUT[c], e_mon.cyc, e_mon.lvl);
                  end else begin
                     $display("ok   tick_ch%0d cyc %0d lvl %0b", c, cyc, clkOUT[c]);
                  end
               end
            end else if (n != 0) begin
               if (c == 0) e_mon = q0[0];
               else        e_mon = q1[0];
               if (e_mon.cyc <= cyc) begin
                  checks++;
                  errors++;
                  $display("FAIL tick_missing ch%0d got none at cyc %0d want tick lvl %0b",
                           c, e_mon.cyc, e_mon.lvl);
                  if (c == 0) void'(q0.pop_front());
                  else        void'(q1.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      rst = 1'b1; wrEn = 1'b0; wrCh = 1'b0; wrDiv = '0; chEn = 2'b00;
      repeat (3) @(negedge clkIN);
      chk("reset_clkOUT",  32'(clkOUT),  0);
      chk("reset_tick",    32'(tick),    0);
      chk("reset_pending", 32'(pending), 0);

      chEn = 2'b11;
      @(negedge clkIN);
      chk("reset_holds_with_en", 32'(clkOUT), 0);
      rst  = 1'b0;
      base = cyc;

      // Channel 0: D=3 (period 8), then D=1, then D=0 from base+28
      push(0, base+4, 1); push(0, base+8, 0); push(0, base+12, 1); push(0, base+16, 0);
      push(0, base+20, 1); push(0, base+22, 0); push(0, base+24, 1); push(0, base+26, 0);
      push(0, base+28, 1);
      for (int n = 29; n <= 46; n++) push(0, base+n, logic'(n % 2 == 0));
      // Channel 1: D=3 throughout, disabled base+30..base+33
      push(1, base+4, 1); push(1, base+8, 0); push(1, base+12, 1); push(1, base+16, 0);
      push(1, base+20, 1); push(1, base+24, 0); push(1, base+28, 1);
      push(1, base+37, 1); push(1, base+41, 0); push(1, base+45, 1);

      // Mid-half-period write D=1 to channel 0
      wait_to(base+17);
      wrEn = 1'b1; wrCh = 1'b0; wrDiv = 32'd1;
      wait_to(base+18);
      wrEn = 1'b0;
      chk("pending_after_write", 32'(pending), 32'b01);
      wait_to(base+19);
      chk("pending_held", 32'(pending), 32'b01);
      wait_to(base+20);
      chk("pending_cleared_at_boundary", 32'(pending), 0);

      // Write D=0 landing on channel 0's terminal count
      wait_to(base+27);
      wrEn = 1'b1; wrCh = 1'b0; wrDiv = 32'd0;
      wait_to(base+28);
      wrEn = 1'b0;
      chk("pending_terminal_write", 32'(pending), 0);

      // Drop channel 1 while its output is high
      wait_to(base+29);
      chk("pending_terminal_write_next", 32'(pending), 0);
      chk("ch1_high_before_disable", 32'(clkOUT[1]), 1);
      chEn = 2'b01;
      wait_to(base+30);
      chk("ch1_low_after_disable", 32'(clkOUT[1]), 0);
      wait_to(base+33);
      chEn = 2'b11;
      wait_to(base+36);
      chk("ch1_low_before_first_rise", 32'(clkOUT[1]), 0);

      wait_to(base+46);
      chEn = 2'b00;
      wait_to(base+47);
      chk("all_low_when_disabled", 32'(clkOUT), 0);
      wait_to(base+48);

      // Reset together with a write: reset wins, divisor stays 3
      rst = 1'b1; wrEn = 1'b1; wrCh = 1'b1; wrDiv = 32'd5; chEn = 2'b11;
      @(negedge clkIN);
      chk("rst_wr_pending", 32'(pending), 0);
      chk("rst_wr_clkOUT",  32'(clkOUT),  0);
      rst = 1'b0; wrEn = 1'b0;
      base = cyc;
      push(0, base+4, 1);
      push(1, base+4, 1);
      wait_to(base+1);
      chk("rst_wr_pending_after", 32'(pending), 0);

      // Reset in the middle of a high half-period
      wait_to(base+5);
      chk("both_high_before_rst", 32'(clkOUT), 32'b11);
      rst = 1'b1;
      wait_to(base+6);
      chk("mid_rst_clkOUT",  32'(clkOUT),  0);
      chk("mid_rst_tick",    32'(tick),    0);
      chk("mid_rst_pending", 32'(pending), 0);

      rst  = 1'b0;
      chEn = 2'b00;
      repeat (3) @(negedge clkIN);
      chk("q0_drained", 32'(q0.size()), 0);
      chk("q1_drained", 32'(q1.size()), 0);
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_multi_clock_divider
